pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8'd255, consecutive data-memory wait cycles tolerated before halting; legal range 1..255.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous and active-low.
REQ-004 SHALL have ports id_rs1_addr, id_rs2_addr  in  5  source register addresses of the instruction in ID.
REQ-005 SHALL have ports ex_rd_addr  in  5 and ex_mem_read  in  1  destination register of the instruction in EX, and a flag marking it as a load.
REQ-006 SHALL have port ex_branch_taken  in  1  EX resolved a taken branch or jump.
REQ-007 SHALL have ports mem_req  in  1 and mem_ready  in  1  MEM-stage data access request and its completion.
REQ-008 SHALL have port pc_en  out  1  PC update enable.
REQ-009 SHALL have ports if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid  out  1  per-stage register load enables.
REQ-010 SHALL have ports if_id_flush, id_ex_flush, mem_wb_flush  out  1  per-stage bubble insertion; a flush overrides the matching valid.
REQ-011 SHALL have ports halted  out  1  sticky timeout halt, and perf_stall_cnt  out  32  stall-cycle count.

Function
REQ-012 SHALL hold a 2-bit state: RUN=0, REDIRECT=1, MEM_WAIT=2, HALT=3.
REQ-013 SHALL define freeze = mem_req && !mem_ready; freeze SHALL take priority over branch and load-use handling in RUN, REDIRECT and MEM_WAIT.
REQ-014 SHALL, on freeze, drive pc_en=0, all *_valid=0, mem_wb_flush=1, and if_id_flush=id_ex_flush=0.
REQ-015 SHALL, when not frozen and ex_branch_taken=1 in RUN or REDIRECT, drive if_id_flush=1, id_ex_flush=1, pc_en=1 and all valids 1, with next state REDIRECT.
REQ-016 SHALL, in REDIRECT without freeze and without branch, drive if_id_flush=1 (discards the wrong-path fetch in flight) and pc_en=1, with next state RUN.
REQ-017 SHALL define load-use = ex_mem_read && ex_rd_addr!=0 && (ex_rd_addr==id_rs1_addr || ex_rd_addr==id_rs2_addr); it SHALL be evaluated only in RUN.
REQ-018 SHALL, on load-use in RUN without freeze or branch, drive pc_en=0, if_id_valid=0, id_ex_flush=1, and ex_mem_valid=mem_wb_valid=1, with no state change.
REQ-019 SHALL otherwise drive pc_en=1, all valids 1 and all flushes 0.
REQ-020 SHALL keep an 8-bit wait_cnt that increments on each freeze cycle and clears on any non-freeze cycle.
REQ-021 SHALL enter MEM_WAIT on freeze, return to RUN when freeze drops, and restore REDIRECT afterwards if freeze began in REDIRECT.
REQ-022 SHALL enter HALT when freeze holds and wait_cnt==MEM_TIMEOUT-1, i.e. after MEM_TIMEOUT consecutive wait cycles.
REQ-023 SHALL, in HALT, drive pc_en=0, all valids 0, all flushes 0 and halted=1, ignoring all inputs until reset.
REQ-024 SHALL produce all outputs combinationally from the current state and inputs, with zero-cycle latency.

Reset
REQ-025 SHALL, on a rising clk with reset=0, set state=RUN, wait_cnt=0 and perf_stall_cnt=0.
REQ-026 SHALL, while reset=0, force pc_en=0, all valids 0, all flushes 0 and halted=0.
REQ-027 SHALL let reset asserted in any state, including HALT or mid-wait, win over every other event.

Configuration
REQ-028 SHALL, with PIPE_CTRL_PERF_EN defined, increment perf_stall_cnt on each post-reset cycle with pc_en=0, saturating at 32'hFFFFFFFF.
REQ-029 SHALL, without PIPE_CTRL_PERF_EN, tie perf_stall_cnt to 32'h0 and instantiate no counter register.

Verification
REQ-030 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> pc_en=0, if_id_valid=0, id_ex_flush=1 for one cycle; ex_rd=0 -> no stall.
REQ-031 SHALL cover branch: ex_branch_taken for 1 cycle -> if_id_flush=1 for 2 cycles, id_ex_flush=1 for the first only, state RUN after.
REQ-032 SHALL cover memory wait: mem_req=1, mem_ready=0 for 3 cycles with MEM_TIMEOUT=4 -> all valids 0, mem_wb_flush=1 for 3 cycles, then RUN, halted=0.
REQ-033 SHALL cover timeout: MEM_TIMEOUT=4, wait held 4 cycles -> halted=1 from cycle 5, persisting after mem_ready=1, cleared by reset=0.
REQ-034 SHALL cover freeze plus branch in the same cycle -> freeze outputs only, with the branch flush taken the cycle mem_ready rises.
REQ-035 SHALL cover the counter with PIPE_CTRL_PERF_EN: 3 load-use plus 2 wait cycles -> perf_stall_cnt=5; without the macro it reads 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, branch redirect, MEM freeze, timeout halt.
// Optional stall-cycle counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_valid,
    output logic        id_ex_valid,
    output logic        ex_mem_valid,
    output logic        mem_wb_valid,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic        halted,
    output logic [31:0] perf_stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       resume_redir;
    logic       resume_redir_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       freeze;
    logic       load_use;
    logic       redir_pending;

    // Hazard detection terms
    always_comb begin
        freeze   = mem_req && !mem_ready;
        load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                   ((ex_rd_addr == id_rs1_addr) ||
                    (ex_rd_addr == id_rs2_addr));
    end

    // Next state and control outputs; leaving MEM_WAIT behaves as the state it froze in
    always_comb begin
        state_nxt        = state;
        resume_redir_nxt = resume_redir;
        wait_cnt_nxt     = 8'd0;
        redir_pending    = 1'b0;
        pc_en            = 1'b0;
        if_id_valid      = 1'b0;
        id_ex_valid      = 1'b0;
        ex_mem_valid     = 1'b0;
        mem_wb_valid     = 1'b0;
        if_id_flush      = 1'b0;
        id_ex_flush      = 1'b0;
        mem_wb_flush     = 1'b0;
        halted           = 1'b0;
        if (!reset) begin
            state_nxt        = RUN;
            resume_redir_nxt = 1'b0;
        end else if (state == HALT) begin
            halted = 1'b1;
        end else if (freeze) begin
            mem_wb_flush = 1'b1;
            wait_cnt_nxt = wait_cnt + 8'd1;
            if (wait_cnt == MEM_TIMEOUT - 8'd1) begin
                state_nxt = HALT;
            end else begin
                state_nxt = MEM_WAIT;
                if (state != MEM_WAIT) begin
                    resume_redir_nxt = (state == REDIRECT);
                end
            end
        end else begin
            redir_pending = (state == REDIRECT) ||
                            ((state == MEM_WAIT) && resume_redir);
            resume_redir_nxt = 1'b0;
            state_nxt        = RUN;
            pc_en            = 1'b1;
            if_id_valid      = 1'b1;
            id_ex_valid      = 1'b1;
            ex_mem_valid     = 1'b1;
            mem_wb_valid     = 1'b1;
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_nxt   = REDIRECT;
            end else if (redir_pending) begin
                if_id_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_valid = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // State, resume flag and wait counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= RUN;
            resume_redir <= 1'b0;
            wait_cnt     <= 8'd0;
        end else begin
            state        <= state_nxt;
            resume_redir <= resume_redir_nxt;
            wait_cnt     <= wait_cnt_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;

    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= 32'd0;
        end else if (!pc_en && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus random
// stimulus compared every cycle against a behavioural model.
module tb_pipe_ctrl;

    localparam logic [7:0] TMO = 8'd4;

    localparam logic [8:0] O_RST  = 9'b0_0000_000_0;
    localparam logic [8:0] O_NORM = 9'b1_1111_000_0;
    localparam logic [8:0] O_FRZ  = 9'b0_0000_001_0;
    localparam logic [8:0] O_BR   = 9'b1_1111_110_0;
    localparam logic [8:0] O_RED  = 9'b1_1111_100_0;
    localparam logic [8:0] O_LU   = 9'b0_0111_010_0;
    localparam logic [8:0] O_HLT  = 9'b0_0000_000_1;

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [31:0] PERF5 = 32'd5;
`else
    localparam logic [31:0] PERF5 = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_rs1_addr = 5'd0;
    logic [4:0]  id_rs2_addr = 5'd0;
    logic [4:0]  ex_rd_addr = 5'd0;
    logic        ex_mem_read = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_en;
    logic        if_id_valid;
    logic        id_ex_valid;
    logic        ex_mem_valid;
    logic        mem_wb_valid;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_flush;
    logic        halted;
    logic [31:0] perf_stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr),
        .ex_rd_addr(ex_rd_addr),
        .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req),
        .mem_ready(mem_ready),
        .pc_en(pc_en),
        .if_id_valid(if_id_valid),
        .id_ex_valid(id_ex_valid),
        .ex_mem_valid(ex_mem_valid),
        .mem_wb_valid(mem_wb_valid),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush),
        .halted(halted),
        .perf_stall_cnt(perf_stall_cnt)
    );

    logic [8:0] outv;
    assign outv = {pc_en, if_id_valid, id_ex_valid, ex_mem_valid,
                   mem_wb_valid, if_id_flush, id_ex_flush,
                   mem_wb_flush, halted};

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Behavioural model: a pending-redirect flag, a consecutive-wait tally,
    // a halt flag and a stall tally.
    bit          live = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_halt = 1'b0;
    int          m_waits = 0;
    logic [31:0] m_stalls = 32'd0;

    logic fz;
    logic lu;
    logic [8:0] exp_v;
    logic [31:0] exp_perf;

    function automatic logic [8:0] model_out(input logic rst, input bit halt,
                                             input bit pend, input logic f,
                                             input logic br, input logic l);
        if (!rst) return O_RST;
        if (halt) return O_HLT;
        if (f) return O_FRZ;
        if (br) return O_BR;
        if (pend) return O_RED;
        if (l) return O_LU;
        return O_NORM;
    endfunction

    assign fz = mem_req && !mem_ready;
    assign lu = ex_mem_read && (ex_rd_addr != 5'd0) &&
                (ex_rd_addr == id_rs1_addr || ex_rd_addr == id_rs2_addr);
    assign exp_v = model_out(reset, m_halt, m_pend, fz, ex_branch_taken, lu);
`ifdef PIPE_CTRL_PERF_EN
    assign exp_perf = m_stalls;
`else
    assign exp_perf = 32'd0;
`endif

    always @(posedge clk) begin
        if (!reset) begin
            live     <= 1'b1;
            m_pend   <= 1'b0;
            m_halt   <= 1'b0;
            m_waits  <= 0;
            m_stalls <= 32'd0;
        end else if (live) begin
            if (!exp_v[8] && m_stalls != 32'hFFFF_FFFF)
                m_stalls <= m_stalls + 32'd1;
            if (!m_halt) begin
                if (fz) begin
                    m_waits <= m_waits + 1;
                    if (m_waits + 1 >= int'(TMO)) m_halt <= 1'b1;
                end else begin
                    m_waits <= 0;
                    m_pend  <= ex_branch_taken;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("ctl", 32'(outv), 32'(exp_v));
            check("perf", perf_stall_cnt, exp_perf);
        end
    end

    task automatic step(input bit rst, input bit [4:0] rs1,
                        input bit [4:0] rs2, input bit [4:0] rd,
                        input bit mr, input bit br,
                        input bit rq, input bit rdy);
        @(posedge clk);
        #1;
        reset = rst;
        id_rs1_addr = rs1;
        id_rs2_addr = rs2;
        ex_rd_addr = rd;
        ex_mem_read = mr;
        ex_branch_taken = br;
        mem_req = rq;
        mem_ready = rdy;
        #1;
    endtask

    task automatic idle();
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frz(input bit br);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, br, 1'b1, 1'b0);
    endtask

    initial begin
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_out", 32'(outv), 32'(O_RST));
        check("rst_perf", perf_stall_cnt, 32'd0);
        idle();
        check("norm", 32'(outv), 32'(O_NORM));

        step(1'b1, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu", 32'(outv), 32'(O_LU));
        idle();
        check("lu_one", 32'(outv), 32'(O_NORM));
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_x0", 32'(outv), 32'(O_NORM));

        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("br1", 32'(outv), 32'(O_BR));
        idle();
        check("br2", 32'(outv), 32'(O_RED));
        idle();
        check("br3", 32'(outv), 32'(O_NORM));

        for (int i = 0; i < 3; i++) begin
            frz(1'b0);
            check("mw", 32'(outv), 32'(O_FRZ));
        end
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("mw_end", 32'(outv), 32'(O_NORM));

        frz(1'b1);
        check("fzbr1", 32'(outv), 32'(O_FRZ));
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("fzbr2", 32'(outv), 32'(O_BR));
        idle();
        check("fzbr3", 32'(outv), 32'(O_RED));
        idle();
        check("fzbr4", 32'(outv), 32'(O_NORM));

        for (int i = 0; i < 4; i++) begin
            frz(1'b0);
            check("tmo_w", 32'(outv), 32'(O_FRZ));
        end
        frz(1'b0);
        check("halt5", 32'(outv), 32'(O_HLT));
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("halt_rdy", 32'(outv), 32'(O_HLT));
        step(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        check("halt_in", 32'(outv), 32'(O_HLT));
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("halt_rst", 32'(outv), 32'(O_RST));
        idle();
        check("halt_clr", 32'(outv), 32'(O_NORM));

        frz(1'b0);
        frz(1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("midw_rst", 32'(outv), 32'(O_RST));
        idle();
        check("midw_run", 32'(outv), 32'(O_NORM));

        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
            check("p_lu", 32'(outv), 32'(O_LU));
        end
        frz(1'b0);
        frz(1'b0);
        idle();
        check("perf5", perf_stall_cnt, PERF5);

        for (int i = 0; i < 4000; i++) begin
            step(1'b1 && ($urandom_range(0, 59) != 0),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 1) == 1);
        end
        idle();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
